counter_seq_ctrl: RTL and testbench

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

---
 rtl/counter_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// Command sequencer driving an external 8-bit loadable up/down counter (LOAD / STEP / GOTO).
// Optional step prescaler enabled by defining COUNTER_SEQ_PRESCALE_EN.
module counter_seq_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_arg,
    input  logic       abort,
    input  logic [3:0] step_div,
    output logic       ctr_en,
    output logic       ctr_load,
    output logic       ctr_up,
    output logic [7:0] ctr_d,
    input  logic [7:0] ctr_q,
    output logic       busy,
    output logic       done,
    output logic       aborted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_GOTO,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_LOAD      = 2'b00,
        OP_STEP_UP   = 2'b01,
        OP_STEP_DOWN = 2'b10,
        OP_GOTO      = 2'b11
    } op_e;

    state_e     state_q, state_d;
    op_e        op_q, op_d;
    logic [7:0] arg_q, arg_d;
    logic [7:0] rem_q, rem_d;
    logic       aborted_q, aborted_d;
    logic       tick;

`ifdef COUNTER_SEQ_PRESCALE_EN
    logic [3:0] div_q, div_d;
    logic [3:0] pcnt_q, pcnt_d;

    // pcnt_q is cleared on accept so the first STEP/GOTO cycle always ticks
    assign tick = (pcnt_q == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            pcnt_q <= '0;
        end else begin
            div_q  <= div_d;
            pcnt_q <= pcnt_d;
        end
    end
`else
    logic unused_step_div;

    assign tick            = 1'b1;
    assign unused_step_div = ^step_div;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            op_q      <= OP_LOAD;
            arg_q     <= '0;
            rem_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            arg_q     <= arg_d;
            rem_q     <= rem_d;
            aborted_q <= aborted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        arg_d     = arg_q;
        rem_d     = rem_q;
        aborted_d = aborted_q;
        ctr_en    = 1'b0;
        ctr_load  = 1'b0;
        ctr_up    = 1'b0;
`ifdef COUNTER_SEQ_PRESCALE_EN
        div_d     = div_q;
        pcnt_d    = pcnt_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d      = op_e'(cmd_op);
                    arg_d     = cmd_arg;
                    rem_d     = cmd_arg;
                    aborted_d = 1'b0;
`ifdef COUNTER_SEQ_PRESCALE_EN
                    div_d     = step_div;
                    pcnt_d    = '0;
`endif
                    unique case (op_e'(cmd_op))
                        OP_LOAD:      state_d = S_LOAD;
                        OP_STEP_UP,
                        OP_STEP_DOWN: state_d = (cmd_arg == '0) ? S_DONE : S_STEP;
                        OP_GOTO:      state_d = S_GOTO;
                        default:      state_d = S_IDLE;
                    endcase
                end
            end

            S_LOAD: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else begin
                    ctr_load = 1'b1;
                    state_d  = S_DONE;
                end
            end

            S_STEP: begin
                ctr_up = (op_q == OP_STEP_UP);
                if (abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (tick) begin
                    ctr_en = 1'b1;
                    rem_d  = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = S_DONE;
                    end
                end
            end

            S_GOTO: begin
                // Direction is a plain unsigned compare; the wrap path is never taken
                ctr_up = (arg_q > ctr_q);
                if (abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (ctr_q == arg_q) begin
                    state_d = S_DONE;
                end else if (tick) begin
                    ctr_en = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef COUNTER_SEQ_PRESCALE_EN
        if (state_q == S_STEP || state_q == S_GOTO) begin
            pcnt_d = tick ? div_q : (pcnt_q - 4'd1);
        end
`endif
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign aborted   = aborted_q;
    assign ctr_d     = arg_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: directed scenarios followed by random commands, checked against
// an arithmetic timing model of each command driving a behavioural 8-bit up/down counter.
module tb_counter_seq_ctrl;

`ifdef COUNTER_SEQ_PRESCALE_EN
    localparam bit PRESCALE = 1'b1;
`else
    localparam bit PRESCALE = 1'b0;
`endif

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;
    localparam logic [1:0] OP_GOTO = 2'b11;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op    = '0;
    logic [7:0] cmd_arg   = '0;
    logic       abort     = 1'b0;
    logic [3:0] step_div  = '0;
    logic       cmd_ready, ctr_en, ctr_load, ctr_up, busy, done, aborted;
    logic [7:0] ctr_d;
    logic [7:0] cq        = '0;

    int tests_run    = 0;
    int tests_failed = 0;

    counter_seq_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .abort     (abort),
        .step_div  (step_div),
        .ctr_en    (ctr_en),
        .ctr_load  (ctr_load),
        .ctr_up    (ctr_up),
        .ctr_d     (ctr_d),
        .ctr_q     (cq),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    always #5 clk = ~clk;

    // The external counter the sequencer drives
    always @(posedge clk) begin
        if (ctr_load)    cq <= ctr_d;
        else if (ctr_en) cq <= ctr_up ? cq + 8'd1 : cq - 8'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command and check every following cycle against the timing model.
    // abort_at: cycle (1 = first cycle after accept) in which abort is raised; 0 = never.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] arg, input logic [3:0] div,
                           input int abort_at, input string name);
        int         p, nmov, done_c, end_c, s, a;
        bit         dir_up, aborting, exp_en, exp_load, exp_done, exp_busy;
        logic [7:0] exp_val;

        exp_val = cq;
        s       = int'(cq);
        a       = int'(arg);
        p       = PRESCALE ? int'(div) + 1 : 1;
        dir_up  = 1'b0;
        nmov    = 0;
        case (op)
            OP_LOAD: done_c = 2;
            OP_UP, OP_DOWN: begin
                nmov   = a;
                dir_up = (op == OP_UP);
                done_c = (a == 0) ? 1 : (a - 1) * p + 2;
            end
            default: begin
                nmov   = (a > s) ? a - s : s - a;
                dir_up = (a > s);
                done_c = (nmov == 0) ? 2 : (nmov - 1) * p + 3;
            end
        endcase
        aborting = (abort_at > 0) && (abort_at < done_c);
        end_c    = aborting ? abort_at + 1 : done_c + 1;

        // Accept cycle; abort alongside cmd_valid in IDLE must not block the accept
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        step_div  = div;
        abort     = 1'($urandom_range(0, 1));
        #1;
        check({name, "/ready0"}, cmd_ready, 1);
        @(posedge clk);

        for (int t = 1; t <= end_c; t++) begin
            @(negedge clk);
            abort     = (t == abort_at) || (t == done_c && !aborting && $urandom_range(0, 1) == 1);
            cmd_valid = (t < end_c) ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_op    = 2'($urandom);
            cmd_arg   = 8'($urandom);
            step_div  = 4'($urandom);
            #1;
            exp_en   = (op != OP_LOAD) && ((t - 1) % p == 0) && ((t - 1) / p < nmov)
                       && (t < done_c) && !(aborting && t >= abort_at);
            exp_load = (op == OP_LOAD) && (t == 1) && !(aborting && abort_at == 1);
            exp_done = !aborting && (t == done_c);
            exp_busy = (t < end_c);
            check({name, "/ctr_en"},   ctr_en,    exp_en);
            check({name, "/ctr_load"}, ctr_load,  exp_load);
            check({name, "/done"},     done,      exp_done);
            check({name, "/busy"},     busy,      exp_busy);
            check({name, "/ready"},    cmd_ready, !exp_busy);
            check({name, "/ctr_d"},    ctr_d,     arg);
            check({name, "/aborted"},  aborted,   (t == end_c) && aborting);
            if (exp_en)
                check({name, "/ctr_up"}, ctr_up, dir_up);
            if (t >= done_c || (aborting && t == end_c))
                check({name, "/up_idle"}, ctr_up, 0);
            if (exp_en)   exp_val = dir_up ? exp_val + 8'd1 : exp_val - 8'd1;
            if (exp_load) exp_val = arg;
            @(posedge clk);
        end
        abort = 1'b0;
        @(negedge clk);
        check({name, "/ctr_q"}, cq, exp_val);
    endtask

    initial begin
        logic [1:0] rop;
        logic [7:0] rarg, cq_hold;
        logic [3:0] rdiv;
        int         rab;

        // Reset state
        #1;
        check("rst/ready", cmd_ready, 1);
        check("rst/busy", busy, 0);
        check("rst/done", done, 0);
        check("rst/aborted", aborted, 0);
        check("rst/ctr_en", ctr_en, 0);
        check("rst/ctr_load", ctr_load, 0);
        check("rst/ctr_up", ctr_up, 0);
        check("rst/ctr_d", ctr_d, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        run_cmd(OP_LOAD, 8'h5A, 4'd0, 0, "load5a");
        run_cmd(OP_LOAD, 8'hFA, 4'd0, 0, "loadfa");
        run_cmd(OP_UP,   8'd10, 4'd0, 0, "up10wrap");
        check("up10wrap/val", cq, 8'h04);
        run_cmd(OP_LOAD, 8'h10, 4'd0, 0, "load10");
        run_cmd(OP_GOTO, 8'h0C, 4'd0, 0, "goto0c");
        check("goto0c/val", cq, 8'h0C);
        run_cmd(OP_GOTO, 8'h0C, 4'd0, 0, "goto_eq");
        run_cmd(OP_LOAD, 8'h80, 4'd0, 0, "load80");
        run_cmd(OP_DOWN, 8'd200, 4'd0, 5, "down_abort");
        check("down_abort/val", cq, 8'h7C);
        run_cmd(OP_LOAD, 8'h00, 4'd0, 0, "load00");
        run_cmd(OP_UP,   8'd3, 4'd2, 0, "up3_div2");
        check("up3_div2/val", cq, 8'h03);
        run_cmd(OP_UP,   8'd0, 4'd0, 0, "up0");
        run_cmd(OP_LOAD, 8'h01, 4'd0, 0, "load01");
        run_cmd(OP_DOWN, 8'd3, 4'd1, 0, "down_wrap");
        check("down_wrap/val", cq, 8'hFE);
        run_cmd(OP_LOAD, 8'h33, 4'd0, 1, "load_abort");

        for (int i = 0; i < 30; i++) begin
            rop  = 2'($urandom);
            rdiv = 4'($urandom_range(0, 3));
            rarg = (rop == OP_UP || rop == OP_DOWN) ? 8'($urandom_range(0, 40)) : 8'($urandom);
            rab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
            run_cmd(rop, rarg, rdiv, rab, "rand");
        end

        // Reset in the middle of a STEP
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_UP;
        cmd_arg   = 8'd50;
        step_div  = 4'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst/ctr_en", ctr_en, 0);
        check("midrst/busy", busy, 0);
        check("midrst/ready", cmd_ready, 1);
        check("midrst/ctr_up", ctr_up, 0);
        check("midrst/ctr_d", ctr_d, 0);
        check("midrst/aborted", aborted, 0);
        cq_hold = cq;
        @(negedge clk);
        reset_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            #1;
            check("postrst/ctr_en", ctr_en, 0);
            check("postrst/done", done, 0);
            check("postrst/busy", busy, 0);
        end
        check("postrst/ctr_q", cq, cq_hold);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
